// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants; the fetch packet is also consumed by decode.
package fetch_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INST_BYTES);
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// In-order FIFO of fetch packets; flush wins over push and pop in the same cycle.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  fetch_pkt_t                   push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output fetch_pkt_t                   head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_pkt_t    mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // Credit accounting upstream guarantees a free slot for every returning word.
  assert property (@(posedge clk_i) disable iff (rst_i) !(do_push && full_o))
    else $error("fetch_queue: push while full");

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word fetches and queues returned words for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst_encoding,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, redir_pc;
  logic [CW-1:0]   out_q, out_d, disc_q, disc_d, count;
  logic            fire, resp_ok, push, pop, full, empty;
  fetch_pkt_t      head, push_pkt;

  assign redir_pc       = {redirect_pc[XLEN-1:2], 2'b00};
  assign imem_req_valid = !rst && ((CW+1)'(out_q) + (CW+1)'(count) < (CW+1)'(QDEPTH));
  assign imem_req_addr  = pc_q;
  assign fire           = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is ignored so the counter cannot wrap.
  assign resp_ok        = imem_resp_valid && (out_q != '0);

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    out_d     = out_q + CW'(fire) - CW'(resp_ok);
    disc_d    = disc_q;
    push      = 1'b0;
    if (resp_ok) begin
      if (disc_q != '0) begin
        disc_d = disc_q - CW'(1);
      end else begin
        push      = 1'b1;
        resp_pc_d = next_pc(resp_pc_q);
      end
    end
    if (fire) pc_d = next_pc(pc_q);
    // Everything still in flight after this cycle, including a fire now, belongs to the old stream.
    if (redirect_valid) begin
      pc_d      = redir_pc;
      resp_pc_d = redir_pc;
      disc_d    = out_d;
      push      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      disc_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      disc_q    <= disc_d;
    end
  end

  assign push_pkt = '{pc: resp_pc_q, inst: imem_resp_data};
  assign pop      = inst_valid && inst_ready && !redirect_valid;

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (push_pkt),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count),
    .head_o      (head)
  );

  assign inst_valid    = !empty;
  assign inst_encoding = empty ? '0 : head.inst;
  assign inst_pc       = empty ? '0 : head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with an in-order memory model and a stream-level reference model.
module tb_fetch_unit;

  localparam int unsigned QD  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_encoding, inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_encoding   (inst_encoding),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] cons_pc[$];
  logic [31:0] cons_enc[$];

  int          ntests = 0, nfail = 0;
  int unsigned cyc = 0;
  int          fires = 0;
  int          buffered = 0;
  logic [31:0] exp_pc = RPC, exp_req = RPC;

  int unsigned p_rdy = 100, p_ird = 0, lat_min = 0, lat_max = 0;
  bit          k_rst = 1'b1, k_redir = 1'b0;
  logic [31:0] k_redir_pc = '0;

  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_ipc, s_enc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One cycle: drive inputs, compare outputs with the model, then advance the model across the edge.
  task automatic step();
    bit    resp, s_fire, s_consume;
    mreq_t m;
    @(negedge clk);
    rst            = k_rst;
    redirect_valid = k_redir && !k_rst;
    redirect_pc    = k_redir_pc;
    k_redir        = 1'b0;
    imem_req_ready = ($urandom_range(99) < p_rdy);
    inst_ready     = ($urandom_range(99) < p_ird);
    resp           = !k_rst && (mq.size() > 0) && (mq[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(mq[0].addr) : $urandom;
    #1;
    s_rv = imem_req_valid; s_iv = inst_valid;
    s_addr = imem_req_addr; s_ipc = inst_pc; s_enc = inst_encoding;
    s_fire    = imem_req_valid && imem_req_ready;
    s_consume = inst_valid && inst_ready;

    chk("req_valid", {31'b0, s_rv}, {31'b0, !k_rst && (mq.size() + buffered < QD)});
    if (s_rv) chk("req_addr", s_addr, exp_req);
    chk("inst_valid", {31'b0, s_iv}, {31'b0, buffered > 0});
    chk("inst_pc", s_ipc, (buffered > 0) ? exp_pc : 32'h0);
    chk("inst_encoding", s_enc, (buffered > 0) ? mem_word(exp_pc) : 32'h0);

    if (k_rst) begin
      mq.delete();
      buffered = 0;
      exp_pc   = RPC;
      exp_req  = RPC;
    end else begin
      if (resp) begin
        if (!mq[0].stale) buffered++;
        void'(mq.pop_front());
      end
      if (s_consume && buffered > 0 && !redirect_valid) begin
        cons_pc.push_back(s_ipc);
        cons_enc.push_back(s_enc);
        buffered--;
        exp_pc += 32'd4;
      end
      if (s_fire) begin
        m.addr  = exp_req;
        m.due   = cyc + 1 + $urandom_range(lat_max, lat_min);
        m.stale = 1'b0;
        mq.push_back(m);
        fires++;
        exp_req += 32'd4;
      end
      if (redirect_valid) begin
        foreach (mq[i]) mq[i].stale = 1'b1;
        buffered = 0;
        exp_pc   = {redirect_pc[31:2], 2'b00};
        exp_req  = {redirect_pc[31:2], 2'b00};
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    k_rst = 1'b1;
    step();
    step();
    k_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] tgts[2];
    tgts[0] = 32'h100;
    tgts[1] = 32'h103;

    // Reset, then two requests go out back to back before credit runs out.
    p_rdy = 100; p_ird = 0; lat_min = 20; lat_max = 20;
    do_reset();
    step(); chk("rst_first_addr", s_addr, RPC);        chk("rst_first_valid", {31'b0, s_rv}, 32'd1);
    step(); chk("rst_second_addr", s_addr, RPC + 32'd4); chk("rst_second_valid", {31'b0, s_rv}, 32'd1);
    step(); chk("rst_credit_stop", {31'b0, s_rv}, 32'd0);

    // Streaming with single-cycle memory.
    lat_min = 0; lat_max = 0; p_ird = 100;
    do_reset();
    cons_pc.delete(); cons_enc.delete();
    for (int i = 0; i < 40 && cons_pc.size() < 4; i++) step();
    for (int i = 0; i < 4; i++)
      chk("stream_pc", (cons_pc.size() > i) ? cons_pc[i] : 32'hDEAD_BEEF, 32'(4 * i));
    chk("stream_enc0", (cons_enc.size() > 0) ? cons_enc[0] : 32'hDEAD_BEEF, 32'h0000_0013);
    chk("stream_enc1", (cons_enc.size() > 1) ? cons_enc[1] : 32'hDEAD_BEEF, 32'h0050_0093);

    // Backpressure from decode.
    p_ird = 0; lat_min = 1; lat_max = 1;
    do_reset();
    fires = 0;
    repeat (10) step();
    chk("bp_fires", 32'(fires), 32'd2);
    chk("bp_req_valid", {31'b0, s_rv}, 32'd0);
    p_ird = 100; step(); p_ird = 0;
    fires = 0;
    repeat (8) step();
    chk("bp_one_more", 32'(fires), 32'd1);

    // Memory stall holds the address.
    p_ird = 100; p_rdy = 100; lat_min = 0; lat_max = 0;
    do_reset();
    fires = 0;
    for (int i = 0; i < 20 && fires < 2; i++) step();
    p_rdy = 0;
    repeat (3) begin
      step();
      chk("stall_addr", s_addr, 32'h8);
    end
    p_rdy = 100;
    repeat (6) step();

    // Redirect with two requests in flight, aligned and misaligned target.
    foreach (tgts[t]) begin
      lat_min = 5; lat_max = 5; p_rdy = 100; p_ird = 100;
      do_reset();
      for (int i = 0; i < 10 && mq.size() < 2; i++) step();
      chk("redir_inflight", 32'(mq.size()), 32'd2);
      k_redir = 1'b1; k_redir_pc = tgts[t];
      step();
      step();
      for (int i = 0; i < 40 && !s_iv; i++) step();
      chk("redir_pc", s_ipc, 32'h100);
      chk("redir_enc", s_enc, mem_word(32'h100));
    end

    // Reset with a full queue.
    p_ird = 0; p_rdy = 100; lat_min = 0; lat_max = 0;
    do_reset();
    for (int i = 0; i < 20 && buffered < QD; i++) step();
    k_rst = 1'b1; step();
    chk("mid_rst_req_valid", {31'b0, s_rv}, 32'd0);
    k_rst = 1'b0; step();
    chk("mid_rst_inst_valid", {31'b0, s_iv}, 32'd0);
    chk("mid_rst_addr", s_addr, RPC);
    chk("mid_rst_restart", {31'b0, s_rv}, 32'd1);

    // Random traffic with redirects (including near address wrap) and occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        p_rdy   = $urandom_range(100, 20);
        p_ird   = $urandom_range(100, 20);
        lat_min = 0;
        lat_max = $urandom_range(3);
      end
      k_redir = ($urandom_range(99) < 4);
      k_redir_pc = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      k_rst = ($urandom_range(499) == 0);
      step();
    end
    k_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
